// File: rtl/full_adder32_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder32_pkg;

  localparam int ADDER_W = 32;

endpackage

// File: rtl/full_adder32_cell.sv
// One-bit full-adder cell; the top chains WIDTH of these into a ripple-carry adder.
module full_adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder32.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and valid tracking.
module full_adder32
  import full_adder32_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             outValid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_ripple
    full_adder1 u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carries into and out of the sign bit disagree.
  assign cout_d = carry[WIDTH];
  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign s         = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_full_adder32.sv
// Scoreboard bench for full_adder32: expected results queued at drive time, popped one cycle later.
module tb_full_adder32;
  import full_adder32_pkg::*;

  localparam int W = ADDER_W;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] s;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  res_t sb[$];
  res_t held;
  res_t got;
  logic expValid;
  int   nVectors = 0;
  int   nMiss    = 0;

  always #5 clk = ~clk;

  full_adder32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  // 33-bit reference: zero-extended sum, overflow from operand/result sign bits.
  function automatic res_t refModel(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] wide;
    res_t       r;
    wide   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.cout = wide[W];
    r.s    = wide[W-1:0];
    r.ovf  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  // Drives one cycle of inputs; results only count while reset is released.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c, input logic v, input res_t exp);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = v;
    expValid = v && !rst;
    if (expValid) sb.push_back(exp);
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    a        = '1;
    b        = '1;
    cin      = 1'b1;
    in_valid = 1'b1;
    expValid = 1'b0;
    held     = '0;
    #3 rst = 1'b1;
    #1;
    nVectors++;
    if ({out_valid, cout, s, ovf} !== '0) begin
      nMiss++;
      $display("[TB] FAIL reset_async: got valid=%b cout=%b s=%h ovf=%b want all zero",
               out_valid, cout, s, ovf);
    end
    repeat (2) @(posedge clk);
    #1;
    nVectors++;
    if ({out_valid, cout, s, ovf} !== '0) begin
      nMiss++;
      $display("[TB] FAIL reset_ignores_inputs: got valid=%b cout=%b s=%h ovf=%b want all zero",
               out_valid, cout, s, ovf);
    end
    @(negedge clk);
    applyStimulus('0, '0, 1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    logic [W-1:0] x, y;
    for (int ia = -5; ia <= 5; ia++) begin
      for (int ib = -5; ib <= 5; ib++) begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          nVectors++;
          if (out_valid !== expValid) begin
            nMiss++;
            $display("[TB] FAIL sweep_valid: got %b want %b", out_valid, expValid);
          end
          if (expValid) held = sb.pop_front();
          got = '{cout, s, ovf};
          nVectors++;
          if (got !== held) begin
            nMiss++;
            $display("[TB] FAIL sweep_result: got %h want %h", got, held);
          end
          x = ia;
          y = ib;
          applyStimulus(x, y, c[0], 1'b1, refModel(x, y, c[0]));
        end
      end
    end
  endtask

  task automatic test_boundary;
    logic [W-1:0] ta [6] = '{32'h0000_0003, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFB, 32'h0000_0000};
    logic [W-1:0] tb [6] = '{32'hFFFF_FFFB, 32'h0000_0001, 32'h0000_0000,
                             32'h8000_0000, 32'h0000_0005, 32'h0000_0000};
    logic         tc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         tv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    res_t         te [6] = '{'{1'b0, 32'hFFFF_FFFF, 1'b0},
                             '{1'b0, 32'h8000_0000, 1'b1},
                             '{1'b1, 32'h0000_0000, 1'b0},
                             '{1'b1, 32'h0000_0000, 1'b1},
                             '{1'b1, 32'h0000_0000, 1'b0},
                             '{1'b0, 32'h0000_0000, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nVectors++;
      if (out_valid !== expValid) begin
        nMiss++;
        $display("[TB] FAIL boundary_valid[%0d]: got %b want %b", i, out_valid, expValid);
      end
      if (expValid) held = sb.pop_front();
      got = '{cout, s, ovf};
      nVectors++;
      if (got !== held) begin
        nMiss++;
        $display("[TB] FAIL boundary_result[%0d]: got %h want %h", i, got, held);
      end
      applyStimulus(ta[i], tb[i], tc[i], tv[i], te[i]);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nVectors++;
      if (out_valid !== expValid) begin
        nMiss++;
        $display("[TB] FAIL hold_valid[%0d]: got %b want %b", i, out_valid, expValid);
      end
      if (expValid) held = sb.pop_front();
      if (i >= 2) begin
        nVectors++;
        if (s !== 32'h1234_5678) begin
          nMiss++;
          $display("[TB] FAIL hold_sum[%0d]: got %h want 12345678", i, s);
        end
      end
      if (i == 0)
        applyStimulus(32'h1234_5670, 32'h0000_0008, 1'b0, 1'b1,
                      '{1'b0, 32'h1234_5678, 1'b0});
      else
        applyStimulus(32'hDEAD_0000 + i, 32'h0BAD_F00D, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    applyStimulus(32'd100, 32'd23, 1'b0, 1'b1, refModel(32'd100, 32'd23, 1'b0));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nVectors++;
    if ({out_valid, cout, s, ovf} !== '0) begin
      nMiss++;
      $display("[TB] FAIL midstream_reset: got valid=%b cout=%b s=%h ovf=%b want all zero",
               out_valid, cout, s, ovf);
    end
    sb.delete();
    held = '0;
    @(negedge clk);
    applyStimulus(32'd5, 32'd6, 1'b1, 1'b1, '0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'd7, 32'd8, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nVectors++;
      if (out_valid !== expValid) begin
        nMiss++;
        $display("[TB] FAIL post_reset_valid[%0d]: got %b want %b", i, out_valid, expValid);
      end
      if (expValid) held = sb.pop_front();
      got = '{cout, s, ovf};
      nVectors++;
      if (got !== held) begin
        nMiss++;
        $display("[TB] FAIL post_reset_result[%0d]: got %h want %h", i, got, held);
      end
      if (i == 1)
        applyStimulus(32'd40, 32'd2, 1'b0, 1'b1, '{1'b0, 32'd42, 1'b0});
      else
        applyStimulus(32'd9, 32'd9, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic         c, v;
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      nVectors++;
      if (out_valid !== expValid) begin
        nMiss++;
        $display("[TB] FAIL random_valid[%0d]: got %b want %b", i, out_valid, expValid);
      end
      if (expValid) held = sb.pop_front();
      got = '{cout, s, ovf};
      nVectors++;
      if (got !== held) begin
        nMiss++;
        $display("[TB] FAIL random_result[%0d]: got %h want %h", i, got, held);
      end
      x = $urandom;
      y = $urandom;
      c = $urandom_range(0, 1) == 1;
      v = (i < 10000) && ($urandom_range(0, 9) != 0);
      applyStimulus(x, y, c, v, refModel(x, y, c));
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_boundary();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule

// File: doc/full_adder32.md
FULL_ADDER32 -- requirements
Module: full_adder32

Interface
REQ-001 Parameter WIDTH, default 32: operand/sum width in bits; the block SHALL be verified at 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a  input  WIDTH  addend A; two's-complement or unsigned, same bit pattern.
REQ-005 b  input  WIDTH  addend B; two's-complement or unsigned.
REQ-006 cin  input  1  carry-in, added at bit 0.
REQ-007 in_valid  input  1  qualifies a/b/cin in the current cycle.
REQ-008 s  output  WIDTH  registered sum.
REQ-009 cout  output  1  registered carry-out from the MSB.
REQ-010 ovf  output  1  registered signed overflow flag.
REQ-011 out_valid  output  1  registered; high when s/cout/ovf hold a result.

Function
REQ-012 The adder SHALL compute {cout, s} = a + b + cin, zero-extended to WIDTH+1 bits; s = result mod 2^WIDTH.
REQ-013 The adder SHALL set ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]), i.e. carry-into-MSB XOR carry-out-of-MSB.
REQ-014 Latency SHALL be exactly 1 clock: inputs sampled on rising edge N appear on s/cout/ovf after edge N.
REQ-015 The design SHALL set out_valid equal to in_valid delayed by one cycle.
REQ-016 s/cout/ovf SHALL load only when in_valid=1 and SHALL hold their previous value when in_valid=0.
REQ-017 The design SHALL accept back-to-back inputs every cycle with no stall and no backpressure.
REQ-018 Boundary: all-ones + 0 + cin=1 SHALL give s=0, cout=1, ovf=0.
REQ-019 Boundary: 0x7FFFFFFF + 1 SHALL give s=0x80000000, cout=0, ovf=1.
REQ-020 Boundary: 0x80000000 + 0x80000000 SHALL give s=0, cout=1, ovf=1.
REQ-021 Combinational path from a/b/cin to the output registers SHALL be a ripple-carry chain of 1-bit full-adder cells.
REQ-022 Outputs SHALL have no combinational path from inputs; all outputs are flop-driven.

Reset
REQ-023 Asserting rst SHALL immediately (without a clock edge) force s=0, cout=0, ovf=0, out_valid=0.
REQ-024 While rst=1, inputs SHALL be ignored; after deassertion, the first result appears 1 cycle after the first in_valid=1 edge.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; no stale out_valid after release.

Structure
REQ-026 A shared package SHALL hold the constant ADDER_W = 32, used as the WIDTH default.
REQ-027 One sub-module, full_adder1 (inputs a, b, cin; outputs s, cout; purely combinational), SHALL be instantiated WIDTH times via generate.
REQ-028 The carry into bit 0 SHALL be cin; the carry out of bit WIDTH-1 SHALL feed cout and the ovf computation.

Verification
REQ-029 Sweep a,b over -5..5 (sign-extended to 32 bits) × cin in {0,1}, in_valid=1 every cycle -> each s equals a+b+cin as a signed value one cycle later; e.g. a=-5, b=5, cin=0 -> s=0, cout=1, ovf=0.
REQ-030 a=3, b=-5, cin=1 -> s=0xFFFFFFFF (-1), cout=0, ovf=0.
REQ-031 a=0x7FFFFFFF, b=1, cin=0 -> s=0x80000000, cout=0, ovf=1; then a=0xFFFFFFFF, b=0, cin=1 -> s=0, cout=1, ovf=0.
REQ-032 Result 0x12345678 held, then in_valid=0 with new operands for 3 cycles -> s stays 0x12345678 and out_valid=0.
REQ-033 Assert rst between clock edges with a result pending -> s=0, cout=0, ovf=0, out_valid=0 immediately; no result emerges after release until a new in_valid.
REQ-034 A random test (10,000 vectors) SHALL compare {cout, s, ovf} against a 33-bit reference model with 1-cycle alignment.
